// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned WORD_W         = BYTES_PER_WORD * BYTE_W;
    localparam int unsigned LANE_W         = $clog2(BYTES_PER_WORD);
    localparam int unsigned LEN_W          = 16;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        BYTES,
        WRITE,
        DONE,
        ERR
    } state_e;

    // True when a header word count fits a memory of 2**addr_w words.
    function automatic logic len_fits(input logic [LEN_W-1:0] n, input int unsigned addr_w);
        return 32'(n) <= (32'd1 << addr_w);
    endfunction

endpackage

// File: rtl/word_packer.sv
// Packs an accepted byte stream little-endian into 32-bit words, one lane per byte.
module word_packer
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              push,
    input  logic [BYTE_W-1:0] data,
    output logic [WORD_W-1:0] word,
    output logic              word_full_c
);

    logic [LANE_W-1:0] lane;

    // Asserted while the byte being pushed completes the word.
    assign word_full_c = push && (lane == LANE_W'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lane <= '0;
            word <= '0;
        end else if (clear) begin
            lane <= '0;
        end else if (push) begin
            word[lane*BYTE_W +: BYTE_W] <= data;
            lane                       <= lane + LANE_W'(1);
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Streams a length-prefixed byte image into instruction memory and releases the core when done.
module imem_boot_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wd,
    output logic              cpu_run,
    output logic              done,
    output logic              error
);

    state_e            state;
    state_e            state_nxt;
    logic [BYTE_W-1:0] len_lo;
    logic [LEN_W-1:0]  hdr_len;
    logic [LEN_W-1:0]  words_left;
    logic              xfer;
    logic              push;
    logic              clear;
    logic              restart;
    logic              word_full_c;
    logic [WORD_W-1:0] word;

    assign xfer    = in_valid && in_ready;
    assign push    = (state == BYTES) && xfer;
    assign hdr_len = {in_data, len_lo};

    word_packer u_packer (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .push        (push),
        .data        (in_data),
        .word        (word),
        .word_full_c (word_full_c)
    );

    assign imem_wd = DATA_W'(word);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath strobes
    always_comb begin
        state_nxt = state;
        restart   = 1'b0;
        clear     = 1'b0;
        case (state)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_nxt = LEN_LO;
                    restart   = 1'b1;
                    clear     = 1'b1;
                end
            end
            LEN_LO: begin
                if (xfer) begin
                    state_nxt = LEN_HI;
                end
            end
            LEN_HI: begin
                if (xfer) begin
                    if (hdr_len == '0) begin
                        state_nxt = DONE;
                    end else if (!len_fits(hdr_len, ADDR_W)) begin
                        state_nxt = ERR;
                    end else begin
                        state_nxt = BYTES;
                    end
                end
            end
            BYTES: begin
                if (word_full_c) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                clear     = 1'b1;
                state_nxt = (words_left == LEN_W'(1)) ? DONE : BYTES;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Registered outputs follow the state being entered; counters track the load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            cpu_run    <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            len_lo     <= '0;
            words_left <= '0;
        end else begin
            in_ready <= (state_nxt inside {LEN_LO, LEN_HI, BYTES});
            imem_we  <= (state_nxt == WRITE);
            cpu_run  <= (state_nxt == DONE);
            done     <= (state_nxt == DONE) && (state != DONE);
            error    <= (state_nxt == ERR);

            if ((state == LEN_LO) && xfer) begin
                len_lo <= in_data;
            end
            if ((state == LEN_HI) && xfer) begin
                words_left <= hdr_len;
            end

            // Address holds on the final word so it never wraps past the top.
            if (restart) begin
                imem_addr <= '0;
            end else if (state == WRITE) begin
                words_left <= words_left - LEN_W'(1);
                if (words_left != LEN_W'(1)) begin
                    imem_addr <= imem_addr + ADDR_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: expected write stream plus a shadow memory model.
module tb_imem_boot_loader;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wd;
    logic              cpu_run;
    logic              done;
    logic              error;

    always #5 clk = ~clk;

    imem_boot_loader #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wd   (imem_wd),
        .cpu_run   (cpu_run),
        .done      (done),
        .error     (error)
    );

    logic [31:0] img [DEPTH];
    logic [31:0] mem [DEPTH];
    int          exp_addr_q [$];
    logic [31:0] exp_data_q [$];

    int          n_cmp = 0;
    int          n_bad = 0;
    int          m_cmp = 0;
    int          m_bad = 0;
    int          wr_cnt = 0;
    int          done_cnt = 0;
    int          last_addr = -1;
    logic        we_prev = 1'b0;
    int          ea;
    logic [31:0] ed;

    // Per-cycle compare: every write must be the next expected (addr, word) of the image.
    always @(negedge clk) begin : compare
        if (!rst_n) begin
            exp_addr_q.delete();
            exp_data_q.delete();
        end
        if (imem_we) begin
            wr_cnt    = wr_cnt + 1;
            last_addr = int'(imem_addr);
            mem[imem_addr] = imem_wd;
            m_cmp = m_cmp + 1;
            if (exp_addr_q.size() == 0) begin
                m_bad = m_bad + 1;
                $display("FAIL unexpected_write: got addr %0h data %08h, required no write", imem_addr, imem_wd);
            end else begin
                ea = exp_addr_q.pop_front();
                ed = exp_data_q.pop_front();
                if ((int'(imem_addr) != ea) || (imem_wd !== ed)) begin
                    m_bad = m_bad + 1;
                    $display("FAIL write: got addr %0h data %08h, required addr %0h data %08h",
                             imem_addr, imem_wd, ea, ed);
                end
            end
            m_cmp = m_cmp + 1;
            if (we_prev || in_ready || cpu_run) begin
                m_bad = m_bad + 1;
                $display("FAIL we_pulse: got we_prev=%0b in_ready=%0b cpu_run=%0b, required 0 0 0",
                         we_prev, in_ready, cpu_run);
            end
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            m_cmp = m_cmp + 1;
            if (!cpu_run) begin
                m_bad = m_bad + 1;
                $display("FAIL done_run: got cpu_run=%0b with done, required 1", cpu_run);
            end
        end
        we_prev = imem_we;
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endfunction

    // Called at a negedge; returns at the negedge after the byte was taken.
    task automatic send_byte(input logic [7:0] b, input int gap);
        logic rdy;
        bit   ok;
        ok = 1'b0;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        for (int t = 0; t < 64; t++) begin
            rdy = in_ready;
            @(posedge clk);
            if (rdy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) chk("byte_accept_timeout", 32'd0, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic do_start(input bit junk);
        start = 1'b1;
        if (junk) begin
            in_valid = 1'b1;
            in_data  = 8'hEE;
        end
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic send_header(input logic [15:0] n);
        send_byte(n[7:0], 0);
        send_byte(n[15:8], 0);
    endtask

    task automatic send_words(input int count, input int gapmax, input int start_at, input int byte_limit);
        int sent;
        logic [31:0] w32;
        sent = 0;
        for (int w = 0; w < count; w++) begin
            exp_addr_q.push_back(w);
            exp_data_q.push_back(img[w]);
            w32 = img[w];
            for (int l = 0; l < 4; l++) begin
                if (sent == byte_limit) return;
                if ((w == start_at) && (l == 2)) do_start(1'b0);
                send_byte(w32[8*l +: 8], (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0);
                sent++;
            end
        end
    endtask

    task automatic wait_end();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 200; t++) begin
            if (cpu_run || error) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) chk("finish_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    // Full legal load, then the generic end-of-load checks.
    task automatic run_load(input string tag, input int n, input int gapmax, input int start_at, input bit do_st);
        int base_wr;
        int base_done;
        base_wr   = wr_cnt;
        base_done = done_cnt;
        if (do_st) do_start(1'b0);
        send_header(16'(n));
        send_words(n, gapmax, start_at, 4 * n);
        wait_end();
        chk({tag, "_writes"}, 32'(wr_cnt - base_wr), 32'(n));
        chk({tag, "_done_pulses"}, 32'(done_cnt - base_done), 32'd1);
        chk({tag, "_cpu_run"}, 32'(cpu_run), 32'd1);
        chk({tag, "_error"}, 32'(error), 32'd0);
        chk({tag, "_pending"}, 32'(exp_addr_q.size()), 32'd0);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_we"}, 32'(imem_we), 32'd0);
        chk({tag, "_addr"}, 32'(imem_addr), 32'd0);
        chk({tag, "_wd"}, imem_wd, 32'd0);
        chk({tag, "_cpu_run"}, 32'(cpu_run), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_error"}, 32'(error), 32'd0);
    endtask

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: got no end of test, required finish within budget");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int errs;
        int base_wr;
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'hAA;

        // Reset held two edges with a byte offered
        repeat (2) @(negedge clk);
        chk_outputs_zero("reset");
        chk("reset_writes", 32'(wr_cnt), 32'd0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 32'd0);

        // Two-word program
        img[0] = 32'h00000013;
        img[1] = 32'h00B505B3;
        run_load("small", 2, 0, -1, 1'b1);
        chk("small_mem0", mem[0], 32'h00000013);
        chk("small_mem1", mem[1], 32'h00B505B3);
        base_wr = done_cnt;
        repeat (3) @(negedge clk);
        chk("small_run_held", 32'(cpu_run), 32'd1);
        chk("small_done_once", 32'(done_cnt - base_wr), 32'd0);

        // Empty image, then oversize header
        run_load("empty", 0, 0, -1, 1'b1);
        base_wr = wr_cnt;
        do_start(1'b0);
        send_header(16'h0401);
        wait_end();
        chk("ovf_error", 32'(error), 32'd1);
        chk("ovf_cpu_run", 32'(cpu_run), 32'd0);
        in_valid = 1'b1;
        in_data  = 8'h55;
        repeat (3) @(negedge clk);
        chk("ovf_in_ready", 32'(in_ready), 32'd0);
        chk("ovf_error_sticky", 32'(error), 32'd1);
        in_valid = 1'b0;
        chk("ovf_writes", 32'(wr_cnt - base_wr), 32'd0);

        // Full capacity with random valid gaps
        for (int i = 0; i < int'(DEPTH); i++) img[i] = $urandom();
        run_load("full", int'(DEPTH), 2, -1, 1'b1);
        chk("full_last_addr", 32'(last_addr), 32'h3FF);
        errs = 0;
        for (int i = 0; i < int'(DEPTH); i++) if (mem[i] !== img[i]) errs++;
        chk("full_readback_errors", 32'(errs), 32'd0);

        // start mid-load is ignored; start after DONE restarts from address 0
        img[0] = 32'h11223344;
        img[1] = 32'hA5A55A5A;
        img[2] = 32'hDEADBEEF;
        run_load("midstart", 3, 0, 1, 1'b1);
        chk("midstart_mem2", mem[2], 32'hDEADBEEF);
        do_start(1'b1);
        chk("restart_cpu_run", 32'(cpu_run), 32'd0);
        chk("restart_in_ready", 32'(in_ready), 32'd1);
        img[0] = 32'hCAFEF00D;
        img[1] = 32'h12345678;
        run_load("reload", 2, 1, -1, 1'b0);
        chk("reload_mem0", mem[0], 32'hCAFEF00D);
        chk("reload_mem1", mem[1], 32'h12345678);

        // Reset after two of three words, then a clean reload
        img[0] = 32'h0BADF00D;
        img[1] = 32'h76543210;
        img[2] = 32'h89ABCDEF;
        base_wr = wr_cnt;
        do_start(1'b0);
        send_header(16'd3);
        send_words(3, 0, -1, 10);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk_outputs_zero("abort");
        chk("abort_writes", 32'(wr_cnt - base_wr), 32'd2);
        chk("abort_mem1", mem[1], 32'h76543210);
        rst_n = 1'b1;
        @(negedge clk);
        img[0] = 32'h01020304;
        img[1] = 32'h05060708;
        img[2] = 32'h090A0B0C;
        run_load("after_abort", 3, 1, -1, 1'b1);
        chk("after_abort_mem0", mem[0], 32'h01020304);
        chk("after_abort_mem2", mem[2], 32'h090A0B0C);

        repeat (2) @(negedge clk);
        n_cmp = n_cmp + m_cmp;
        n_bad = n_bad + m_bad;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
